// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: Moore datapath controls, memory-wait handshake, retired-instruction counter.
// Optional LUI support is enabled by defining MULTICYCLE_CONTROL_LUI_EN.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        mem_valid,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
`ifdef MULTICYCLE_CONTROL_LUI_EN
        S_LUI,
`endif
        S_ILLEGAL
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;
    logic        w_retire;
    logic        w_pcw;
    logic        w_irw;
    logic        w_rw;

    // Subtract only exists for register-register ops with funct7[5] set.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic is_r, input logic f7);
        case (f3)
            3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   w_next = mem_valid ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    7'b0000011: w_next = S_MEMADR;
                    7'b0110011: w_next = S_EXECR;
                    7'b0010011: w_next = S_EXECI;
                    7'b1100011: w_next = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    7'b1101111: w_next = S_JAL;
`ifdef MULTICYCLE_CONTROL_LUI_EN
                    7'b0110111: w_next = S_LUI;
`endif
                    default:    w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  w_next = S_MEMREAD;
            S_MEMREAD: w_next = mem_valid ? S_MEMWB : S_MEMREAD;
            S_MEMWB:   w_next = S_FETCH;
            S_EXECR:   w_next = S_ALUWB;
            S_EXECI:   w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BEQ:     w_next = S_FETCH;
            S_JAL:     w_next = S_ALUWB;
`ifdef MULTICYCLE_CONTROL_LUI_EN
            S_LUI:     w_next = S_ALUWB;
`endif
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_FETCH;
        endcase
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // Moore decode of the state register; only FETCH and BEQ look at live inputs.
    always_comb begin
        w_pcw      = 1'b0;
        w_irw      = 1'b0;
        w_rw       = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = 2'd0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irw     = mem_valid;
                w_pcw     = mem_valid;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == 7'b1101111) ? 2'd3 : 2'd1;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_rw      = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, 1'b1, funct7b5);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, 1'b0, funct7b5);
            end
            S_ALUWB: w_rw = 1'b1;
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                w_pcw      = Zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_pcw   = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_LUI_EN
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'd2;
            end
`endif
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    // Architectural write enables are suppressed for the whole reset cycle.
    assign PCWrite  = w_pcw & ~rst;
    assign IRWrite  = w_irw & ~rst;
    assign RegWrite = w_rw & ~rst;
    assign instret  = r_instret;

endmodule
